// File: rtl/tlk2711_axi_rd_resp.sv
// tlk2711_axi_rd_resp: AXI4 read responder serving a 16-bit-lane counting pattern with burst checks and stats
module tlk2711_axi_rd_resp #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int AR_LATENCY = 2,
  parameter int GAP        = 0
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  input  logic                  i_clr,
  output logic [31:0]           o_beat_cnt,
  output logic [15:0]           o_burst_cnt,
  output logic                  o_prot_err
);
  localparam int LANES = DATA_WIDTH / 16;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  typedef enum logic [1:0] {S_IDLE, S_LAT, S_BEAT, S_GAP} state_t;
  state_t state, state_nx;
  logic [31:0] cnt;
  logic [7:0] len, idx;
  logic [15:0] seed;
  logic [DATA_WIDTH-1:0] pat;
  logic ar_hs, r_hs, ar_err, araddr_unused;
  logic [31:0] span;
  assign araddr_unused = ^s_araddr[ADDR_WIDTH-1:12];
  assign s_arready = state == S_IDLE;
  assign s_rvalid  = state == S_BEAT;
  assign s_rlast   = s_rvalid && idx == len;
  assign s_rdata   = s_rvalid ? pat : '0;
  assign ar_hs     = s_arvalid && s_arready;
  assign r_hs      = s_rvalid && s_rready;
  // 4 KB check done 32 bits wide so a full 256-beat burst cannot wrap the sum
  assign span   = 32'(s_araddr[11:0]) + (32'(s_arlen) + 32'd1) * 32'(BYTES);
  assign ar_err = s_arburst != 2'b01 || s_arsize != 3'(SIZE) || span > 32'd4096;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign pat[16*k +: 16] = seed + 16'(k);
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (ar_hs) state_nx = AR_LATENCY == 1 ? S_BEAT : S_LAT;
      S_LAT:   if (cnt == 32'(AR_LATENCY - 2)) state_nx = S_BEAT;
      S_BEAT:  if (r_hs) state_nx = idx == len ? S_IDLE : (GAP > 0 ? S_GAP : S_BEAT);
      default: if (cnt == 32'(GAP - 1)) state_nx = S_BEAT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      len         <= '0;
      idx         <= '0;
      seed        <= '0;
      s_rid       <= '0;
      s_rresp     <= '0;
      o_beat_cnt  <= '0;
      o_burst_cnt <= '0;
      o_prot_err  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= state_nx != state ? '0 : cnt + 32'd1;
      if (ar_hs) begin
        s_rid   <= s_arid;
        len     <= s_arlen;
        idx     <= '0;
        s_rresp <= ar_err ? 2'b10 : 2'b00;
      end
      if (r_hs) begin
        idx  <= idx + 8'd1;
        seed <= seed + 16'(LANES);
      end
      o_beat_cnt  <= i_clr ? '0 : o_beat_cnt + 32'(r_hs);
      o_burst_cnt <= i_clr ? '0 : o_burst_cnt + 16'(r_hs && s_rlast);
      o_prot_err  <= !i_clr && (o_prot_err || (ar_hs && ar_err));
    end
  end
endmodule

// File: tb/tb_tlk2711_axi_rd_resp.sv
// tb_tlk2711_axi_rd_resp: scoreboard bench for the AXI read responder (GAP=0 main unit, GAP=2 unit for long bursts)
module tb_tlk2711_axi_rd_resp;
  logic clk = 0, rst_n = 0;
  logic arvalid = 0, rready, clr = 0, rr_mode = 0;
  logic [3:0] arid = 0;
  logic [31:0] araddr = 0;
  logic [7:0] arlen = 0;
  logic [2:0] arsize = 3'd4;
  logic [1:0] arburst = 2'b01;
  logic s_arready, s_rvalid, s_rlast, o_prot_err;
  logic [127:0] s_rdata;
  logic [3:0] s_rid;
  logic [1:0] s_rresp;
  logic [31:0] o_beat_cnt;
  logic [15:0] o_burst_cnt;
  logic arvalid_b = 0, rready_b = 1;
  logic [3:0] arid_b = 4'd9;
  logic [31:0] araddr_b = 0;
  logic [7:0] arlen_b = 8'd255;
  logic [2:0] arsize_b = 3'd4;
  logic [1:0] arburst_b = 2'b01;
  logic b_arready, b_rvalid, b_rlast, b_prot_err;
  logic [127:0] b_rdata;
  logic [3:0] b_rid;
  logic [1:0] b_rresp;
  logic [31:0] b_beat_cnt;
  logic [15:0] b_burst_cnt;
  int tests = 0, fails = 0, beats = 0;
  typedef struct packed {logic [127:0] d; logic [3:0] id; logic [1:0] resp; logic last;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [15:0] m_seed = 0;

  tlk2711_axi_rd_resp #(.AR_LATENCY(2), .GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .s_arvalid(arvalid), .s_arready(s_arready), .s_arid(arid),
    .s_araddr(araddr), .s_arlen(arlen), .s_arsize(arsize), .s_arburst(arburst),
    .s_rvalid(s_rvalid), .s_rready(rready), .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .i_clr(clr), .o_beat_cnt(o_beat_cnt), .o_burst_cnt(o_burst_cnt),
    .o_prot_err(o_prot_err));

  tlk2711_axi_rd_resp #(.AR_LATENCY(2), .GAP(2)) dut_gap (
    .clk(clk), .rst_n(rst_n), .s_arvalid(arvalid_b), .s_arready(b_arready), .s_arid(arid_b),
    .s_araddr(araddr_b), .s_arlen(arlen_b), .s_arsize(arsize_b), .s_arburst(arburst_b),
    .s_rvalid(b_rvalid), .s_rready(rready_b), .s_rdata(b_rdata), .s_rid(b_rid), .s_rresp(b_rresp),
    .s_rlast(b_rlast), .i_clr(clr), .o_beat_cnt(b_beat_cnt), .o_burst_cnt(b_burst_cnt),
    .o_prot_err(b_prot_err));

  initial forever #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    rready = 1;
    forever begin
      @(posedge clk);
      #1;
      rready = rr_mode ? ~rready : 1'b1;
    end
  end

  function automatic logic [127:0] pat(input logic [15:0] s);
    logic [127:0] p;
    for (int k = 0; k < 8; k++) p[16*k +: 16] = s + 16'(k);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ctl"}, {s_arready, s_rvalid, s_rlast, s_rresp, s_rid}, 9'h100);
    chk({nm, "_data"}, s_rdata, 0);
    chk({nm, "_stats"}, {o_beat_cnt, o_burst_cnt, o_prot_err}, 0);
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic err);
    bit ok = 0;
    for (int i = 0; i <= int'(len); i++) begin
      q.push_back('{pat(m_seed), id, err ? 2'b10 : 2'b00, i == int'(len)});
      m_seed += 16'd8;
    end
    @(posedge clk);
    #1;
    arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = 3'd4; arburst = burst;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = s_arready;
    end
    chk("ar_accept", ok, 1);
    @(posedge clk);
    #1;
    arvalid = 0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      #1;
      done = q.size() == 0 && s_arready;
    end
    chk("drain", done, 1);
  endtask

  task automatic clear();
    @(posedge clk);
    #1;
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
  endtask

  logic stalled = 0, st_l;
  logic [127:0] st_d;
  always @(negedge clk) begin
    if (!rst_n) stalled = 0;
    else if (s_rvalid) begin
      if (stalled) chk("stall_hold", {s_rdata, s_rlast}, {st_d, st_l});
      if (rready) begin
        stalled = 0;
        beats++;
        if (q.size() == 0) chk("beat_expected", q.size(), 1);
        else begin
          e = q.pop_front();
          chk("r_beat", {s_rdata, s_rid, s_rresp, s_rlast}, e);
        end
      end else begin
        stalled = 1;
        st_d = s_rdata;
        st_l = s_rlast;
      end
    end
  end

  int b_idle = 0, b_idx = 0, b_beats = 0;
  logic [15:0] b_seed = 0;
  bit b_mid = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_rvalid) begin
        if (b_mid) chk("t5_gap", b_idle, 2);
        chk("t5_beat", {b_rdata, b_rlast, b_rresp}, {pat(b_seed), b_idx == 255, 2'b00});
        b_seed += 16'd8;
        b_mid = b_idx != 255;
        b_idx = b_idx == 255 ? 0 : b_idx + 1;
        b_idle = 0;
        b_beats++;
      end else b_idle++;
    end
  end

  initial begin
    bit ok;
    int base;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1;
    issue(4'd1, 32'h0, 8'd3, 2'b01, 0);
    chk("t1_arready_drop", s_arready, 0);
    chk("t1_lat_c1", s_rvalid, 0);
    @(posedge clk);
    #1;
    chk("t1_lat_c2", s_rvalid, 1);
    chk("t1_beat0", s_rdata, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    drain();
    chk("t1_cnt", {o_beat_cnt, o_burst_cnt}, {32'd4, 16'd1});
    rr_mode = 1;
    issue(4'd2, 32'h0, 8'd3, 2'b01, 0);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = s_rvalid;
    end
    chk("t2_lane0", {ok, s_rdata[15:0]}, {1'b1, 16'd32});
    drain();
    rr_mode = 0;
    chk("t2_cnt", {o_beat_cnt, o_burst_cnt}, {32'd8, 16'd2});
    issue(4'd3, 32'h0, 8'd3, 2'b10, 1);
    drain();
    chk("t3_err", {o_prot_err, o_beat_cnt, o_burst_cnt}, {1'b1, 32'd12, 16'd3});
    clear();
    chk("t3_clr", {o_beat_cnt, o_burst_cnt, o_prot_err}, 0);
    issue(4'd4, 32'hFF0, 8'd1, 2'b01, 1);
    drain();
    chk("t4_cross_err", o_prot_err, 1);
    clear();
    issue(4'd5, 32'hFE0, 8'd1, 2'b01, 0);
    drain();
    chk("t4_edge_ok", {o_prot_err, o_beat_cnt, o_burst_cnt}, {1'b0, 32'd2, 16'd1});
    for (int n = 0; n < 33; n++) begin
      @(posedge clk);
      #1;
      arvalid_b = 1;
      ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
        @(negedge clk);
        ok = b_arready;
      end
      chk("t5_ar", ok, 1);
      @(posedge clk);
      #1;
      arvalid_b = 0;
    end
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = b_beats == 33 * 256 && b_arready;
    end
    chk("t5_done", {ok, b_beat_cnt, b_burst_cnt}, {1'b1, 32'd8448, 16'd33});
    base = beats;
    issue(4'd6, 32'h0, 8'd15, 2'b01, 0);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = beats == base + 5;
    end
    chk("t6_reach_beat5", ok, 1);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk_reset("t6_reset");
    q.delete();
    m_seed = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    issue(4'd7, 32'h0, 8'd1, 2'b01, 0);
    drain();
    chk("t6_cnt", {o_beat_cnt, o_burst_cnt, o_prot_err}, {32'd2, 16'd1, 1'b0});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
